bnn_inst_fetch: RTL and testbench
=================================

# bnn_inst_fetch

Instruction fetch stage that sits directly upstream of the BNN controller (BPUCtrl). It walks a program counter through the instruction SRAM, absorbs the SRAM's one-cycle read latency with a small prefetch FIFO, and presents 16-bit instructions to the controller over a valid/ready handshake. It also handles controller-issued jump redirects by flushing stale instructions, and signals program completion.

## Interface
Parameters:
- ADDR_W, 10, instruction SRAM address width
- INST_W, 16, instruction width; fixed at 16 for the controller
- FIFO_DEPTH, 4, prefetch FIFO entries; power of two, at least 2

Ports:
- clk  input  1  clock; all logic rising-edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse: begin fetching at start_addr; ignored while busy
- start_addr  input  ADDR_W  first instruction address
- end_addr  input  ADDR_W  last instruction address (inclusive); sampled with start
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when the program has fully drained
- imem_en  output  1  SRAM read enable
- imem_addr  output  ADDR_W  SRAM read address
- imem_rdata  input  INST_W  SRAM read data, valid the cycle after imem_en
- inst_valid  output  1  inst/inst_pc hold a valid instruction
- inst_ready  input  1  controller accepts the instruction this cycle
- inst  output  INST_W  instruction to the controller, i.e. BPUCtrl.inst
- inst_pc  output  ADDR_W  address of inst
- redirect  input  1  controller jump: discard all fetched instructions
- redirect_pc  input  ADDR_W  new fetch address

## Operation
- States:
  - IDLE: waits for start. On start, latch end_addr, set fetch_pc=start_addr, go to RUN.
  - RUN: issues reads.
  - DRAIN: fetch_pc > end_addr; waits for the FIFO to empty and for any in-flight read to complete, then pulses done and returns to IDLE.
- Read issue in RUN: imem_en=1 when fetch_pc <= end_addr and occupancy + inflight < FIFO_DEPTH. imem_addr=fetch_pc; fetch_pc increments on issue. inflight is 0 or 1.
- Return: the cycle after issue, imem_rdata and its pc are pushed into the FIFO unless the kill flag is set.
- Output: the FIFO head drives inst, inst_pc and inst_valid. A pop occurs on inst_valid & inst_ready.
- Redirect, when asserted in cycle t:
  - The FIFO is cleared at the end of cycle t.
  - Any read issued in cycle t, or still in flight from cycle t-1, is killed.
  - fetch_pc becomes redirect_pc and the state becomes RUN.
  - Redirect overrides a simultaneous pop or push.
  - If redirect_pc > end_addr, go to DRAIN instead of RUN.
  - In IDLE, redirect is ignored.
- fetch_pc comparisons are unsigned. Increment at the maximum address saturates to the DRAIN condition; it does not wrap to 0.
- Pop and push in the same cycle on a full FIFO is legal; occupancy is unchanged.
- Reset (asynchronous, rst=0): state IDLE; FIFO empty; inflight and kill cleared. All outputs are 0: busy, done, imem_en, imem_addr, inst_valid, inst, inst_pc.
- Reset mid-program discards everything; no done pulse is generated.

## Timing
- start in cycle 0: busy=1 and imem_en=1 with imem_addr=start_addr in cycle 1. Data returns in cycle 2; inst_valid=1 in cycle 3.
- Steady state: one instruction per cycle when inst_ready is held high. The credit rule never overflows the FIFO.
- Redirect in cycle t: inst_valid=0 in cycle t+1, with imem_en=1 and imem_addr=redirect_pc in t+1. First redirected instruction is valid in t+3.
- inst and inst_pc are stable while inst_valid=1 and inst_ready=0.
- done: the cycle after the last instruction is popped with no inflight read, done=1 for one cycle. busy=0 in that same cycle; state is IDLE.
- start_addr > end_addr: RUN→DRAIN immediately, no reads issued; done pulses in cycle 2.

## Test plan
- Straight program: start_addr=0, end_addr=7, SRAM[i]=16'h0800+i, inst_ready=1.
  - Required: inst_valid in cycles 3..10 with inst=0800..0807 and inst_pc=0..7; done in cycle 11.
- Back-pressure: same program with inst_ready=0 for cycles 3..12.
  - Required: imem_en stops after 4 reads; inst holds 0800 steady; no loss or duplication after ready rises.
- Redirect: program 0..15; assert redirect with redirect_pc=2 on acceptance of inst_pc=6.
  - Required: instructions with inst_pc 7..9 never appear valid; next valid inst_pc=2 exactly 3 cycles later.
- Redirect past end: end_addr=5; redirect_pc=9 at inst_pc=3.
  - Required: no further inst_valid; done pulses once within 2 cycles.
- Async reset mid-run: drop rst in cycle 6 with the FIFO half full.
  - Required: all outputs 0 immediately. After release, a new start at address 4 fetches from 4 with no stale instructions.
- Empty range and ignored start: start with start_addr=5, end_addr=3.
  - Required: no imem_en; done in cycle 2.
  - Also: a start pulse while busy has no effect on fetch_pc.

Source files
------------

// File: rtl/bnn_inst_fetch.sv
// Instruction fetch for the BNN controller: walks a PC through the instruction SRAM,
// buffers returning words in a small prefetch FIFO and handles jump redirects.
module bnn_inst_fetch #(
  parameter int ADDR_W     = 10,
  parameter int INST_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              busy,
  output logic              done,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] data;
  } entry_t;

  state_t            state;
  // One extra bit so incrementing past the top address lands beyond end_addr.
  logic [ADDR_W:0]   fetch_pc;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] ret_pc;
  logic              inflight;
  logic              kill;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  entry_t            mem [FIFO_DEPTH];

  logic              redir;
  logic              credit_ok;
  logic              issue;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count_next;
  logic [ADDR_W:0]   pc_next;
  logic              finish;
  entry_t            head;

  assign redir      = redirect && (state != IDLE);
  assign credit_ok  = ({1'b0, count} + (CNT_W+1)'(inflight)) < (CNT_W+1)'(FIFO_DEPTH);
  assign issue      = (state == RUN) && (fetch_pc <= {1'b0, last_addr}) && credit_ok;
  assign imem_en    = issue;
  assign imem_addr  = issue ? fetch_pc[ADDR_W-1:0] : '0;

  assign inst_valid = (count != '0);
  assign head       = mem[rd_ptr];
  assign inst       = inst_valid ? head.data : '0;
  assign inst_pc    = inst_valid ? head.pc   : '0;

  // A redirect in the same cycle drops both the returning word and the pop.
  assign push       = inflight && !kill && !redir;
  assign pop        = inst_valid && inst_ready && !redir;
  assign count_next = redir ? '0 : count + CNT_W'(push) - CNT_W'(pop);
  assign pc_next    = redir ? {1'b0, redirect_pc} : fetch_pc + (ADDR_W+1)'(issue);
  assign finish     = (state != IDLE) && (pc_next > {1'b0, last_addr}) &&
                      (count_next == '0) && !issue;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      fetch_pc  <= '0;
      last_addr <= '0;
      ret_pc    <= '0;
      inflight  <= 1'b0;
      kill      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      kill     <= redir && issue;
      count    <= count_next;
      if (issue) ret_pc <= fetch_pc[ADDR_W-1:0];

      if (redir) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end

      if (state == IDLE) begin
        if (start) begin
          last_addr <= end_addr;
          fetch_pc  <= {1'b0, start_addr};
          state     <= RUN;
          busy      <= 1'b1;
        end
      end else begin
        fetch_pc <= pc_next;
        if (finish) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= (pc_next > {1'b0, last_addr}) ? DRAIN : RUN;
        end
      end
    end
  end

  // NOTE: FIFO storage carries no reset; count gates every read of it, and
  // outputs are forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: ret_pc, data: imem_rdata};
  end

endmodule

// File: tb/tb_bnn_inst_fetch.sv
// Directed bench for bnn_inst_fetch: straight-line fetch, back-pressure, redirects,
// async reset, empty range and ignored start, against a behavioural SRAM.
module tb_bnn_inst_fetch;
  localparam int ADDR_W = 10;
  localparam int INST_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic              busy, done, imem_en, inst_valid;
  logic [ADDR_W-1:0] imem_addr, inst_pc;
  logic [INST_W-1:0] imem_rdata = '0;
  logic [INST_W-1:0] inst;
  logic              inst_ready = 1'b0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [INST_W-1:0] sram [1 << ADDR_W];

  bnn_inst_fetch #(.ADDR_W(ADDR_W), .INST_W(INST_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .end_addr(end_addr),
    .busy(busy), .done(done), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = 16'h0800 + 16'(i);

  always @(posedge clk) if (imem_en) imem_rdata <= sram[imem_addr];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 of a new program (start was high in cycle 0).
  task automatic launch(input int sa, input int ea);
    start = 1'b1; start_addr = ADDR_W'(sa); end_addr = ADDR_W'(ea);
    tick;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #3;
    vectors++;
    if ({busy, done, imem_en, imem_addr, inst_valid, inst, inst_pc} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b en=%b addr=%0d v=%b inst=%h pc=%0d, need all 0",
               busy, done, imem_en, imem_addr, inst_valid, inst, inst_pc);
    end
    tick; rst = 1'b1; tick;
  endtask

  task automatic test_straight;
    inst_ready = 1'b1;
    launch(0, 7);
    for (int c = 1; c <= 12; c++) begin
      logic exp_v;
      if (c == 1) begin
        vectors++;
        if (busy !== 1'b1 || imem_en !== 1'b1 || imem_addr !== 10'd0) begin
          miscompares++;
          $display("FAIL straight_c1: busy=%b en=%b addr=%0d, need 1 1 0", busy, imem_en, imem_addr);
        end
      end
      exp_v = (c >= 3 && c <= 10);
      vectors++;
      if (inst_valid !== exp_v) begin
        miscompares++;
        $display("FAIL straight_valid c%0d: got %b need %b", c, inst_valid, exp_v);
      end
      if (exp_v) begin
        vectors++;
        if (inst !== 16'h0800 + 16'(c - 3) || inst_pc !== ADDR_W'(c - 3)) begin
          miscompares++;
          $display("FAIL straight_data c%0d: got %h@%0d need %h@%0d", c, inst, inst_pc,
                   16'h0800 + 16'(c - 3), c - 3);
        end
      end
      vectors++;
      if (done !== (c == 11) || (c == 11 && busy !== 1'b0)) begin
        miscompares++;
        $display("FAIL straight_done c%0d: done=%b busy=%b need done=%b", c, done, busy, c == 11);
      end
      tick;
    end
  endtask

  task automatic test_back_pressure;
    int en_cnt = 0, got = 0, done_seen = 0;
    launch(0, 7);
    for (int c = 1; c <= 40; c++) begin
      inst_ready = (c < 3 || c > 12);
      #1;
      if (c <= 12 && imem_en) en_cnt++;
      if (c >= 3 && c <= 12) begin
        vectors++;
        if (inst_valid !== 1'b1 || inst !== 16'h0800 || inst_pc !== 10'd0) begin
          miscompares++;
          $display("FAIL bp_hold c%0d: v=%b inst=%h pc=%0d need 1 0800 0", c, inst_valid, inst, inst_pc);
        end
      end
      if (inst_valid && inst_ready) begin
        vectors++;
        if (inst_pc !== ADDR_W'(got) || inst !== 16'h0800 + 16'(got)) begin
          miscompares++;
          $display("FAIL bp_order: got %h@%0d need pc %0d", inst, inst_pc, got);
        end
        got++;
      end
      if (done) begin done_seen++; break; end
      tick;
    end
    tick;
    vectors++;
    if (en_cnt != 4 || got != 8 || done_seen != 1) begin
      miscompares++;
      $display("FAIL bp_totals: reads=%0d pops=%0d done=%0d need 4 8 1", en_cnt, got, done_seen);
    end
  endtask

  task automatic test_redirect;
    int t = -1, next_pc = 0, done_seen = 0;
    inst_ready = 1'b1;
    launch(0, 15);
    for (int c = 1; c <= 80; c++) begin
      if (t < 0 && inst_valid && inst_pc == 10'd6) begin
        redirect = 1'b1; redirect_pc = 10'd2; t = c;
      end
      if (t >= 0 && c == t + 1) begin
        vectors++;
        if (inst_valid !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 10'd2) begin
          miscompares++;
          $display("FAIL redir_t1: v=%b en=%b addr=%0d need 0 1 2", inst_valid, imem_en, imem_addr);
        end
      end
      if (t >= 0 && c == t + 2) begin
        vectors++;
        if (inst_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL redir_t2: v=%b need 0", inst_valid);
        end
      end
      if (t >= 0 && c == t + 3) begin
        vectors++;
        if (inst_valid !== 1'b1 || inst_pc !== 10'd2 || inst !== 16'h0802) begin
          miscompares++;
          $display("FAIL redir_t3: v=%b %h@%0d need 1 0802@2", inst_valid, inst, inst_pc);
        end
      end
      if (inst_valid && inst_ready && !redirect) begin
        vectors++;
        if (inst_pc !== ADDR_W'(next_pc)) begin
          miscompares++;
          $display("FAIL redir_order: got pc %0d need %0d", inst_pc, next_pc);
        end
        next_pc++;
      end
      if (redirect) next_pc = 2;
      if (done) begin done_seen++; break; end
      tick;
      redirect = 1'b0;
    end
    tick;
    vectors++;
    if (t < 0 || next_pc != 16 || done_seen != 1) begin
      miscompares++;
      $display("FAIL redir_totals: t=%0d next_pc=%0d done=%0d need t>=0 16 1", t, next_pc, done_seen);
    end
  endtask

  task automatic test_redirect_past_end;
    int t = -1, done_win = 0, done_all = 0, next_pc = 0;
    inst_ready = 1'b1;
    launch(0, 5);
    for (int c = 1; c <= 40; c++) begin
      if (t < 0 && inst_valid && inst_pc == 10'd3) begin
        redirect = 1'b1; redirect_pc = 10'd9; t = c;
      end
      if (t < 0 && inst_valid && inst_ready) begin
        vectors++;
        if (inst_pc !== ADDR_W'(next_pc)) begin
          miscompares++;
          $display("FAIL pastend_order: got pc %0d need %0d", inst_pc, next_pc);
        end
        next_pc++;
      end
      if (t >= 0 && c > t) begin
        vectors++;
        if (inst_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL pastend_valid c%0d: v=%b pc=%0d need 0", c, inst_valid, inst_pc);
        end
        if (done) begin
          done_all++;
          if (c <= t + 2) done_win++;
        end
      end
      if (t >= 0 && c == t + 6) break;
      tick;
      redirect = 1'b0;
    end
    vectors++;
    if (t < 0 || done_win != 1 || done_all != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL pastend_done: t=%0d in_window=%0d total=%0d busy=%b need 1 1 0", t, done_win, done_all, busy);
    end
    tick;
  endtask

  task automatic test_async_reset;
    int next_pc = 4, done_seen = 0;
    launch(0, 15);
    for (int c = 1; c < 6; c++) begin
      inst_ready = (c == 3 || c == 4);
      tick;
    end
    inst_ready = 1'b0;
    #1;
    vectors++;
    if (inst_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pre: v=%b busy=%b need 1 1", inst_valid, busy);
    end
    rst = 1'b0;
    #2;
    vectors++;
    if ({busy, done, imem_en, imem_addr, inst_valid, inst, inst_pc} !== '0) begin
      miscompares++;
      $display("FAIL rst_async: busy=%b done=%b en=%b addr=%0d v=%b inst=%h pc=%0d need all 0",
               busy, done, imem_en, imem_addr, inst_valid, inst, inst_pc);
    end
    tick; rst = 1'b1; tick;
    inst_ready = 1'b1;
    launch(4, 7);
    for (int c = 1; c <= 30; c++) begin
      if (c == 1) begin
        vectors++;
        if (imem_en !== 1'b1 || imem_addr !== 10'd4) begin
          miscompares++;
          $display("FAIL rst_restart: en=%b addr=%0d need 1 4", imem_en, imem_addr);
        end
      end
      if (inst_valid && inst_ready) begin
        vectors++;
        if (inst_pc !== ADDR_W'(next_pc) || inst !== 16'h0800 + 16'(next_pc)) begin
          miscompares++;
          $display("FAIL rst_order: got %h@%0d need pc %0d", inst, inst_pc, next_pc);
        end
        next_pc++;
      end
      if (done) begin done_seen++; break; end
      tick;
    end
    tick;
    vectors++;
    if (next_pc != 8 || done_seen != 1) begin
      miscompares++;
      $display("FAIL rst_totals: next_pc=%0d done=%0d need 8 1", next_pc, done_seen);
    end
  endtask

  task automatic test_empty_range;
    launch(5, 3);
    for (int c = 1; c <= 3; c++) begin
      vectors++;
      if (imem_en !== 1'b0 || done !== (c == 2) || busy !== (c == 1)) begin
        miscompares++;
        $display("FAIL empty c%0d: en=%b done=%b busy=%b need 0 %b %b", c, imem_en, done, busy,
                 c == 2, c == 1);
      end
      tick;
    end
  endtask

  task automatic test_ignored_start;
    int next_pc = 0, done_seen = 0, bad_addr = 0;
    inst_ready = 1'b1;
    launch(0, 7);
    for (int c = 1; c <= 30; c++) begin
      start = (c == 2);
      if (c == 2) begin start_addr = 10'd20; end_addr = 10'd30; end
      #1;
      if (imem_en && imem_addr > 10'd7) bad_addr++;
      if (inst_valid && inst_ready) begin
        vectors++;
        if (inst_pc !== ADDR_W'(next_pc)) begin
          miscompares++;
          $display("FAIL ign_order: got pc %0d need %0d", inst_pc, next_pc);
        end
        next_pc++;
      end
      if (done) begin done_seen++; break; end
      tick;
    end
    start = 1'b0;
    tick;
    vectors++;
    if (bad_addr != 0 || next_pc != 8 || done_seen != 1) begin
      miscompares++;
      $display("FAIL ign_totals: stray_reads=%0d next_pc=%0d done=%0d need 0 8 1", bad_addr, next_pc, done_seen);
    end
  endtask

  initial begin
    test_reset;
    test_straight;
    test_back_pressure;
    test_redirect;
    test_redirect_past_end;
    test_async_reset;
    test_empty_range;
    test_ignored_start;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
